// File: rtl/snes_pad_poller_if.sv
// Pad-side and consumer-side signal bundle for the SNES pad poller.
// The poller drives through the master modport; the consumer uses slave.
interface snes_pad_poller_if #(
    parameter int NUM_PADS = 2
);
    logic                     enable;
    logic [NUM_PADS-1:0]      serial_data;
    logic [NUM_PADS-1:0]      snes_clk;
    logic [NUM_PADS-1:0]      data_latch;
    logic [12*NUM_PADS-1:0]   buttons;
    logic [12*NUM_PADS-1:0]   pressed;
    logic [NUM_PADS-1:0]      connected;
    logic                     valid;

    modport master (
        input  enable, serial_data,
        output snes_clk, data_latch, buttons, pressed, connected, valid
    );

    modport slave (
        output enable, serial_data,
        input  snes_clk, data_latch, buttons, pressed, connected, valid
    );
endinterface

// File: rtl/snes_pad_poller.sv
// Multi-pad SNES controller poller: tick divider, latch/shift FSM, per-frame
// button words with rising-edge pulses and connection detection.
module snes_pad_poller #(
    parameter int NUM_PADS   = 2,
    parameter int CLK_DIV    = 21,
    parameter int POLL_TICKS = 2000
) (
    input  logic                 clk,
    input  logic                 reset,
    snes_pad_poller_if.master    bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(POLL_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LATCH    = 2'd1,
        SHIFT_LO = 2'd2,
        SHIFT_HI = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [GAP_W-1:0]            gap_q, gap_d;
    logic [3:0]                  bit_idx_q, bit_idx_d;
    logic [NUM_PADS-1:0]         sync1_q, sync1_d;
    logic [NUM_PADS-1:0]         sync2_q, sync2_d;
    logic [NUM_PADS-1:0][15:0]   raw_q, raw_d;
    logic [12*NUM_PADS-1:0]      buttons_q, buttons_d;
    logic [12*NUM_PADS-1:0]      pressed_q, pressed_d;
    logic [NUM_PADS-1:0]         connected_q, connected_d;
    logic                        valid_q, valid_d;
    logic                        sclk_q, sclk_d;
    logic                        latch_q, latch_d;
    logic                        tick_s;

    assign tick_s = (div_q == DIV_MAX);

    // Next-state, sampling and frame-update logic.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        bit_idx_d   = bit_idx_q;
        raw_d       = raw_q;
        buttons_d   = buttons_q;
        pressed_d   = '0;
        connected_d = connected_q;
        valid_d     = 1'b0;
        sync1_d     = bus.serial_data;
        sync2_d     = sync1_q;
        div_d       = tick_s ? '0 : div_q + DIV_W'(1);

        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    if (gap_q == GAP_MAX) begin
                        if (bus.enable) begin
                            state_d   = LATCH;
                            gap_d     = '0;
                            bit_idx_d = 4'd0;
                        end else begin
                            gap_d = gap_q;
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else begin
                    gap_d = gap_q;
                end
            end
            LATCH: begin
                // bit_idx doubles as the two-tick latch counter
                if (tick_s) begin
                    if (bit_idx_q == 4'd1) begin
                        state_d   = SHIFT_LO;
                        bit_idx_d = 4'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            SHIFT_LO: begin
                if (tick_s) begin
                    for (int p = 0; p < NUM_PADS; p++) begin
                        raw_d[p][bit_idx_q] = ~sync2_q[p];
                    end
                    state_d = SHIFT_HI;
                end else begin
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_HI: begin
                if (tick_s) begin
                    if (bit_idx_q == 4'd15) begin
                        for (int p = 0; p < NUM_PADS; p++) begin
                            buttons_d[12*p +: 12] = raw_q[p][11:0];
                            pressed_d[12*p +: 12] = raw_q[p][11:0] & ~buttons_q[12*p +: 12];
                            connected_d[p]        = (raw_q[p][15:12] == 4'b0000);
                        end
                        valid_d   = 1'b1;
                        state_d   = IDLE;
                        bit_idx_d = 4'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        state_d   = SHIFT_LO;
                    end
                end else begin
                    state_d = SHIFT_HI;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = 4'd0;
            end
        endcase

        // Pad pins are registered from the next state so they align with state_q.
        case (state_d)
            LATCH:    begin sclk_d = 1'b1; latch_d = 1'b1; end
            SHIFT_LO: begin sclk_d = 1'b0; latch_d = 1'b0; end
            default:  begin sclk_d = 1'b1; latch_d = 1'b0; end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            gap_q       <= '0;
            bit_idx_q   <= 4'd0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            raw_q       <= '0;
            buttons_q   <= '0;
            pressed_q   <= '0;
            connected_q <= '0;
            valid_q     <= 1'b0;
            sclk_q      <= 1'b1;
            latch_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            bit_idx_q   <= bit_idx_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            raw_q       <= raw_d;
            buttons_q   <= buttons_d;
            pressed_q   <= pressed_d;
            connected_q <= connected_d;
            valid_q     <= valid_d;
            sclk_q      <= sclk_d;
            latch_q     <= latch_d;
        end
    end

    assign bus.snes_clk   = {NUM_PADS{sclk_q}};
    assign bus.data_latch = {NUM_PADS{latch_q}};
    assign bus.buttons    = buttons_q;
    assign bus.pressed    = pressed_q;
    assign bus.connected  = connected_q;
    assign bus.valid      = valid_q;
endmodule

// File: tb/tb_snes_pad_poller.sv
// Directed bench for snes_pad_poller with a behavioural two-pad shift model.
module tb_snes_pad_poller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    snes_pad_poller_if #(.NUM_PADS(2)) bus ();

    snes_pad_poller #(.NUM_PADS(2), .CLK_DIV(4), .POLL_TICKS(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pad model: latch reloads index 0, each snes_clk rise advances one bit.
    logic [15:0] pad_word [2];
    logic [1:0]  unplug = 2'b00;
    logic [4:0]  pad_idx = 5'd0;
    logic        sclk_prev = 1'b1;

    always @(posedge clk) begin
        sclk_prev <= bus.snes_clk[0];
        if (bus.data_latch[0]) pad_idx <= 5'd0;
        else if (bus.snes_clk[0] && !sclk_prev && pad_idx < 5'd16) pad_idx <= pad_idx + 5'd1;
    end

    logic [1:0] line_s;
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (unplug[p]) line_s[p] = 1'b0;
            else if (pad_idx > 5'd15) line_s[p] = 1'b0;
            else line_s[p] = ~pad_word[p][pad_idx[3:0]];
        end
    end
    assign bus.serial_data = line_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observes one frame from the current negedge until valid (or budget expiry).
    task automatic frame_mon(output int latch_n, output int latch_len, output int lo_pulses,
                             output int bad, output int valid_n, output logic [23:0] b,
                             output logic [23:0] pr, output logic [1:0] cn);
        int cur = 0;
        latch_n = 0; latch_len = 0; lo_pulses = 0; bad = 0; valid_n = 0;
        b = '0; pr = '0; cn = '0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.data_latch !== 2'b00 && bus.data_latch !== 2'b11) bad++;
            if (bus.data_latch[0]) begin
                if (latch_n == 0) latch_n = n;
                latch_len++;
            end
            if (bus.snes_clk === 2'b00) cur++;
            else if (bus.snes_clk === 2'b11) begin
                if (cur > 0) begin
                    lo_pulses++;
                    if (cur != 4) bad++;
                    cur = 0;
                end
            end else bad++;
            if (!bus.valid && bus.pressed !== 24'h0) bad++;
            if (bus.valid) begin
                valid_n = n; b = bus.buttons; pr = bus.pressed; cn = bus.connected;
                break;
            end
        end
    endtask

    task automatic wait_falls(input int k, output int ok);
        int cnt = 0;
        logic prev = bus.snes_clk[0];
        ok = 0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); @(negedge clk);
            if (prev && !bus.snes_clk[0]) cnt++;
            prev = bus.snes_clk[0];
            if (cnt == k) begin ok = 1; break; end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sclk"},  {30'd0, bus.snes_clk},   32'h3);
        chk({tag, "_latch"}, {30'd0, bus.data_latch}, 32'h0);
        chk({tag, "_btn"},   {8'd0, bus.buttons},     32'h0);
        chk({tag, "_prs"},   {8'd0, bus.pressed},     32'h0);
        chk({tag, "_conn"},  {30'd0, bus.connected},  32'h0);
        chk({tag, "_valid"}, {31'd0, bus.valid},      32'h0);
    endtask

    initial begin
        int ln, ll, lp, bad, vn, ok, cnt_latch, cnt_valid;
        logic [23:0] b, pr;
        logic [1:0]  cn;

        pad_word[0] = 16'h0101;
        pad_word[1] = 16'h0000;
        bus.enable  = 1'b0;

        // Reset and idle with enable low
        repeat (5) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        cnt_latch = 0; cnt_valid = 0; ok = 0;
        for (int n = 0; n < 500; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.data_latch !== 2'b00) cnt_latch++;
            if (bus.valid !== 1'b0) cnt_valid++;
            if (bus.snes_clk !== 2'b11) ok++;
        end
        chk("idle_latch", cnt_latch, 0);
        chk("idle_valid", cnt_valid, 0);
        chk("idle_sclk",  ok, 0);
        chk("idle_btn",   {8'd0, bus.buttons}, 32'h0);

        // Frame A: release reset with enable high
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        rst_n = 1'b1;
        frame_mon(ln, ll, lp, bad, vn, b, pr, cn);
        chk("A_latch_n",   ln, 32);
        chk("A_latch_len", ll, 8);
        chk("A_lo_pulses", lp, 16);
        chk("A_bad",       bad, 0);
        chk("A_valid_n",   vn, 168);
        chk("A_btn",       {8'd0, b},  32'h000101);
        chk("A_prs",       {8'd0, pr}, 32'h000101);
        chk("A_conn",      {30'd0, cn}, 32'h3);

        // Frame B: add Start on pad0
        pad_word[0] = 16'h0109;
        frame_mon(ln, ll, lp, bad, vn, b, pr, cn);
        chk("B_latch_n", ln, 32);
        chk("B_valid_n", vn, 168);
        chk("B_bad",     bad, 0);
        chk("B_btn",     {8'd0, b},  32'h000109);
        chk("B_prs",     {8'd0, pr}, 32'h000008);

        // Frame C: identical buttons
        frame_mon(ln, ll, lp, bad, vn, b, pr, cn);
        chk("C_valid_n", vn, 168);
        chk("C_btn",     {8'd0, b},  32'h000109);
        chk("C_prs",     {8'd0, pr}, 32'h000000);
        chk("C_conn",    {30'd0, cn}, 32'h3);

        // Frame D: pad1 unplugged
        unplug[1] = 1'b1;
        frame_mon(ln, ll, lp, bad, vn, b, pr, cn);
        chk("D_valid_n", vn, 168);
        chk("D_btn",     {8'd0, b},  32'hFFF109);
        chk("D_prs",     {8'd0, pr}, 32'hFFF000);
        chk("D_conn",    {30'd0, cn}, 32'h1);

        // Frame E: enable dropped during bit 5
        unplug[1] = 1'b0;
        wait_falls(6, ok);
        chk("E_fall6", ok, 1);
        bus.enable = 1'b0;
        frame_mon(ln, ll, lp, bad, vn, b, pr, cn);
        chk("E_valid_n", vn, 88);
        chk("E_btn",     {8'd0, b},  32'h000109);
        chk("E_conn",    {30'd0, cn}, 32'h3);
        cnt_latch = 0; cnt_valid = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.data_latch !== 2'b00) cnt_latch++;
            if (bus.valid !== 1'b0) cnt_valid++;
        end
        chk("E_no_latch", cnt_latch, 0);
        chk("E_no_valid", cnt_valid, 0);
        bus.enable = 1'b1;
        frame_mon(ln, ll, lp, bad, vn, b, pr, cn);
        chk("E_relatch_n", ln, 4);
        chk("E_revalid_n", vn, 140);

        // Frame F: reset during SHIFT_LO of bit 9
        wait_falls(10, ok);
        chk("F_fall10", ok, 1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        cnt_valid = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.valid !== 1'b0) cnt_valid++;
        end
        chk("F_no_valid", cnt_valid, 0);
        rst_n = 1'b1;
        frame_mon(ln, ll, lp, bad, vn, b, pr, cn);
        chk("F_latch_n", ln, 32);
        chk("F_valid_n", vn, 168);
        chk("F_btn",     {8'd0, b},  32'h000109);
        chk("F_prs",     {8'd0, pr}, 32'h000109);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
